sipo_rx: RTL and testbench
==========================

// Module: sipo_rx
// PURPOSE
//   Serial-in/parallel-out receiver: the receive end of the team's MSB-first 1-bit serial link.
//   Assembles WIDTH serial bits into a parallel word and offers it on a valid/ready output port.
//   Sits between a serial source (shift-out transmitter, pin sampler) and parallel logic.
//   Flags overruns and framing errors.
// PARAMETERS
//   WIDTH      4   bits per word, >=1
//   MSB_FIRST  1   1: first received bit lands in dout[WIDTH-1]; 0: first bit lands in dout[0]
// PORTS
//   clk         in   1      single clock, all logic on posedge
//   reset       in   1      asynchronous, active-low; asserts immediately, release sync'd by integrator
//   sin         in   1      serial data bit
//   sin_valid   in   1      sin is sampled on this edge
//   sin_start   in   1      qualified by sin_valid: this bit is bit 0 of a new frame
//   dout        out  WIDTH  received word, stable while dout_valid=1
//   dout_valid  out  1      word available
//   dout_ready  in   1      consumer accepts the word on this edge when dout_valid=1
//   busy        out  1      frame in progress (state==SHIFT)
//   overrun     out  1      sticky: a completed word was dropped
//   frame_err   out  1      sticky: sin_start seen mid-frame
//   clr_err     in   1      synchronous clear of overrun and frame_err
// BEHAVIOUR
//   Reset (reset=0):
//     - state=IDLE, shift reg=0, cnt=0.
//     - dout=0, dout_valid=0, busy=0, overrun=0, frame_err=0.
//   Bit counter: cnt is $clog2(WIDTH+1) bits wide and counts bits taken in the current frame.
//   Shift: only on cycles with sin_valid=1.
//     - MSB_FIRST=1: sh <= {sh[WIDTH-2:0], sin}.
//     - MSB_FIRST=0: sh <= {sin, sh[WIDTH-1:1]}.
//   State IDLE:
//     - sin_valid & sin_start: take the bit, cnt=1, go to SHIFT.
//     - sin_valid & !sin_start: ignore the bit (no hunting).
//   State SHIFT, on sin_valid:
//     - sin_start=1: resync. Discard partial data, take this bit as bit 0, cnt=1, set frame_err.
//     - otherwise: take the bit, cnt++.
//     - sin_valid=0: hold all state.
//   Word complete (the WIDTH-th bit taken): go to IDLE, cnt=0, then transfer:
//     - If the output register is free, or freed this same edge: dout <= full word,
//       dout_valid=1 after that same edge. Latency is 0 cycles after the last bit edge.
//     - If dout_valid=1 & !dout_ready: keep the old dout, drop the new word, set overrun.
//   WIDTH=1: a start bit completes the word on the same edge. State stays IDLE.
//   Output handshake:
//     - dout_valid falls on the edge where dout_ready=1, unless a new word loads on that edge.
//     - dout and dout_valid change only at the handshake or at a word transfer.
//     - dout_ready is ignored while dout_valid=0.
//   Simultaneous events:
//     - Completion and dout_ready on the same edge: load the new word, dout_valid stays 1, no overrun.
//     - clr_err and a new error on the same edge: the error wins (flag stays set).
//   Reset mid-frame or mid-handshake:
//     - Partial word and pending dout are lost.
//     - All outputs return to their reset values asynchronously.
//   Registered outputs: every output except busy. busy is a decode of the state register.
// STRUCTURE
//   Package sipo_pkg:
//     - state typedef {IDLE, SHIFT}.
//     - localparam function for the cnt width.
//   Sub-module sipo_out_reg: one-entry valid/ready holding register.
//     - Inputs: load, data, ready.
//     - Outputs: dout, dout_valid, drop. drop drives the overrun flag.
//   Top holds the FSM, the shift register, the counter and the sticky flags.
// TESTING  (WIDTH=4, MSB_FIRST=1 unless noted)
//   1. Frame 1,0,1,1 (start on the first bit), dout_ready=1
//      -> dout=4'hB, dout_valid=1 for one cycle, on the edge of the 4th bit.
//   2. Two back-to-back frames A then 5, dout_ready=0 until both are done
//      -> dout stays 4'hA, overrun=1. After clr_err, overrun=0.
//   3. Bits 1,1 then sin_start with bits 0,1,1,0
//      -> frame_err=1, dout=4'h6, no leftover bits from the first frame.
//   4. Gaps: sin_valid low for 3 cycles between each bit of frame C
//      -> dout=4'hC. busy=1 from the first bit until the last bit.
//   5. Reset pulsed after 2 bits, then a full frame 9
//      -> all outputs 0 during reset. Next dout=4'h9, frame_err=0.
//   6. MSB_FIRST=0, bits 1,0,0,0 -> dout=4'h1.
//      Loopback from a 4-bit parallel-in shift-out transmitter
//      -> every pattern 0..F is received intact.

Source files
------------

// File: rtl/sipo_pkg.sv
`default_nettype none
// ============================================================================
// Package : sipo_pkg
// Purpose : Shared types and helpers for the sipo_rx serial receiver.
//           - state_t : receiver FSM state encoding
//           - cnt_w() : width of the per-frame bit counter for a given WIDTH
// Revision: 1.0 - initial release
// ============================================================================
package sipo_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Counter must be able to hold the value WIDTH itself.
  function automatic int cnt_w(input int w);
    return (w < 1) ? 1 : $clog2(w + 1);
  endfunction

endpackage : sipo_pkg
`default_nettype wire

// File: rtl/sipo_out_reg.sv
`default_nettype none
// ============================================================================
// Module  : sipo_out_reg
// Purpose : One-entry valid/ready holding register for received words.
// Ports   : clk          - clock (posedge)
//           reset        - asynchronous, active-low
//           i_load       - a completed word is offered this edge
//           i_data       - the completed word
//           i_ready      - consumer accepts the held word this edge
//           o_dout       - held word
//           o_dout_valid - held word is valid
//           o_drop       - offered word is being discarded (entry full, no accept)
// Revision: 1.0 - initial release
// ============================================================================
module sipo_out_reg #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_dout_valid,
  output logic             o_drop
);

  logic [WIDTH-1:0] r_dout;
  logic             r_valid;
  logic             w_free;

  // Entry counts as free if empty or being drained on this very edge.
  assign w_free = ~r_valid | i_ready;
  assign o_drop = i_load & ~w_free;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_dout  <= '0;
      r_valid <= 1'b0;
    end else if (i_load && w_free) begin
      r_dout  <= i_data;
      r_valid <= 1'b1;
    end else if (r_valid && i_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign o_dout       = r_dout;
  assign o_dout_valid = r_valid;

endmodule : sipo_out_reg
`default_nettype wire

// File: rtl/sipo_rx.sv
`default_nettype none
// ============================================================================
// Module  : sipo_rx
// Purpose : Serial-in/parallel-out receiver. Assembles WIDTH serial bits
//           into a word and offers it on a valid/ready port. Flags overruns
//           and framing errors (sticky, cleared by clr_err).
// Ports   : clk, reset (async active-low)
//           sin, sin_valid, sin_start - serial input and framing
//           dout, dout_valid, dout_ready - parallel output handshake
//           busy - frame in progress
//           overrun, frame_err - sticky error flags; clr_err clears them
// Revision: 1.0 - initial release
// ============================================================================
module sipo_rx
  import sipo_pkg::*;
#(
  parameter int WIDTH     = 4,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             sin,
  input  logic             sin_valid,
  input  logic             sin_start,
  output logic [WIDTH-1:0] dout,
  output logic             dout_valid,
  input  logic             dout_ready,
  output logic             busy,
  output logic             overrun,
  output logic             frame_err,
  input  logic             clr_err
);

  localparam int CW = cnt_w(WIDTH);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_sh;
  logic [WIDTH-1:0] w_sh_base;
  logic [WIDTH-1:0] w_sh_next;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [CW-1:0]    w_cnt_inc;
  logic             w_take;
  logic             w_done;
  logic             w_resync;
  logic             w_drop;
  logic             r_overrun;
  logic             r_frame_err;

  // In IDLE only a start bit is accepted; in SHIFT every valid bit is.
  assign w_take   = sin_valid & (sin_start | (r_state == SHIFT));
  assign w_resync = sin_valid & sin_start & (r_state == SHIFT);

  // A start bit begins from an empty register so no partial data survives.
  assign w_sh_base = sin_start ? '0 : r_sh;

  generate
    if (MSB_FIRST) begin : g_msb_first
      assign w_sh_next = (w_sh_base << 1) | WIDTH'(sin);
    end else begin : g_lsb_first
      assign w_sh_next = (w_sh_base >> 1) | (WIDTH'(sin) << (WIDTH - 1));
    end
  endgenerate

  assign w_cnt_inc = sin_start ? CW'(1) : (r_cnt + CW'(1));
  assign w_done    = w_take & (w_cnt_inc == CW'(WIDTH));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    if (w_take) begin
      if (w_done) begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end else begin
        w_state_nxt = SHIFT;
        w_cnt_nxt   = w_cnt_inc;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_sh    <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_take) begin
        r_sh <= w_sh_next;
      end
    end
  end

  // Sticky flags: a new error on the same edge as clr_err keeps the flag set.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_overrun   <= (r_overrun & ~clr_err) | w_drop;
      r_frame_err <= (r_frame_err & ~clr_err) | w_resync;
    end
  end

  // The completed word goes straight from the shift path into the output
  // register, so it is visible right after the last bit's edge.
  sipo_out_reg #(
    .WIDTH (WIDTH)
  ) u_out_reg (
    .clk          (clk),
    .reset        (reset),
    .i_load       (w_done),
    .i_data       (w_sh_next),
    .i_ready      (dout_ready),
    .o_dout       (dout),
    .o_dout_valid (dout_valid),
    .o_drop       (w_drop)
  );

  assign busy      = (r_state == SHIFT);
  assign overrun   = r_overrun;
  assign frame_err = r_frame_err;

endmodule : sipo_rx
`default_nettype wire

// File: tb/tb_sipo_rx.sv
`default_nettype none
// ============================================================================
// Module  : tb_sipo_rx
// Purpose : Self-checking bench for sipo_rx. Expected words are queued when
//           a frame is sent; monitors pop and compare at each handshake.
//           Flags, busy and reset values are checked directly.
// Revision: 1.0 - initial release
// ============================================================================
module tb_sipo_rx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, clr_err;
  // MSB-first instance
  logic       sin, sin_valid, sin_start, dout_ready;
  logic [3:0] dout;
  logic       dout_valid, busy, overrun, frame_err;
  // LSB-first instance
  logic       l_sin, l_valid, l_start, l_ready;
  logic [3:0] l_dout;
  logic       l_dout_valid, l_busy, l_overrun, l_frame_err;

  int tests = 0;
  int fails = 0;
  logic [3:0] exp_q[$];
  logic [3:0] lexp_q[$];

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b1)) dut (
    .clk(clk), .reset(reset), .sin(sin), .sin_valid(sin_valid),
    .sin_start(sin_start), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .busy(busy), .overrun(overrun),
    .frame_err(frame_err), .clr_err(clr_err)
  );

  sipo_rx #(.WIDTH(4), .MSB_FIRST(1'b0)) dut_lsb (
    .clk(clk), .reset(reset), .sin(l_sin), .sin_valid(l_valid),
    .sin_start(l_start), .dout(l_dout), .dout_valid(l_dout_valid),
    .dout_ready(l_ready), .busy(l_busy), .overrun(l_overrun),
    .frame_err(l_frame_err), .clr_err(clr_err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitors: a handshake completes on the next posedge when valid&ready.
  always @(negedge clk) begin
    if (reset && dout_valid && dout_ready) begin
      if (exp_q.size() == 0) begin
        check("msb_unexpected_word", 32'(dout), 32'hFFFF_FFFF);
      end else begin
        check("msb_word", 32'(dout), 32'(exp_q.pop_front()));
      end
    end
    if (reset && l_dout_valid && l_ready) begin
      if (lexp_q.size() == 0) begin
        check("lsb_unexpected_word", 32'(l_dout), 32'hFFFF_FFFF);
      end else begin
        check("lsb_word", 32'(l_dout), 32'(lexp_q.pop_front()));
      end
    end
  end

  // All stimulus tasks start and end at posedge+1.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bit(input logic b, input logic st);
    sin = b; sin_valid = 1'b1; sin_start = st;
    tick(1);
    sin_valid = 1'b0; sin_start = 1'b0;
  endtask

  task automatic lsb_bit(input logic b, input logic st);
    l_sin = b; l_valid = 1'b1; l_start = st;
    tick(1);
    l_valid = 1'b0; l_start = 1'b0;
  endtask

  // Parallel-in shift-out transmitter, MSB first.
  task automatic tx_word(input logic [3:0] w, input int gap);
    logic [3:0] sh;
    sh = w;
    for (int i = 0; i < 4; i++) begin
      send_bit(sh[3], (i == 0));
      sh = sh << 1;
      if (gap > 0) tick(gap);
    end
  endtask

  task automatic pulse_clr();
    clr_err = 1'b1;
    tick(1);
    clr_err = 1'b0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b0; clr_err = 1'b0;
    sin = 0; sin_valid = 0; sin_start = 0; dout_ready = 0;
    l_sin = 0; l_valid = 0; l_start = 0; l_ready = 0;
    tick(2);
    check("reset_dout", 32'(dout), 0);
    check("reset_flags", {dout_valid, busy, overrun, frame_err}, 0);
    reset = 1'b1;
    tick(1);

    // 1: frame 1011, ready high; word visible right after 4th bit edge
    dout_ready = 1'b1;
    exp_q.push_back(4'hB);
    send_bit(1, 1);
    check("t1_busy_mid", busy, 1);
    send_bit(0, 0); send_bit(1, 0); send_bit(1, 0);
    check("t1_valid_after_last", dout_valid, 1);
    check("t1_dout", 32'(dout), 32'hB);
    check("t1_busy_end", busy, 0);
    tick(1);
    check("t1_valid_one_cycle", dout_valid, 0);

    // 2: A then 5 back-to-back while blocked -> keep A, overrun
    dout_ready = 1'b0;
    tx_word(4'hA, 0);
    tx_word(4'h5, 0);
    check("t2_dout_kept", 32'(dout), 32'hA);
    check("t2_valid", dout_valid, 1);
    check("t2_overrun", overrun, 1);
    check("t2_no_frame_err", frame_err, 0);
    pulse_clr();
    check("t2_overrun_cleared", overrun, 0);
    exp_q.push_back(4'hA);
    dout_ready = 1'b1;
    tick(1);
    check("t2_drained", dout_valid, 0);

    // 3: bits 1,1 then resync with 0110
    exp_q.push_back(4'h6);
    send_bit(1, 1); send_bit(1, 0);
    send_bit(0, 1); send_bit(1, 0); send_bit(1, 0); send_bit(0, 0);
    check("t3_frame_err", frame_err, 1);
    check("t3_dout", 32'(dout), 32'h6);
    tick(1);
    pulse_clr();
    check("t3_frame_err_cleared", frame_err, 0);

    // 4: frame C with 3 idle cycles between bits; busy held across gaps
    exp_q.push_back(4'hC);
    send_bit(1, 1); tick(3);
    check("t4_busy_gap1", busy, 1);
    check("t4_no_valid_gap", dout_valid, 0);
    send_bit(1, 0); tick(3);
    send_bit(0, 0); tick(3);
    check("t4_busy_gap3", busy, 1);
    send_bit(0, 0);
    check("t4_busy_done", busy, 0);
    check("t4_dout", 32'(dout), 32'hC);
    tick(2);

    // 5: pending word F and 2 partial bits lost by async reset
    dout_ready = 1'b0;
    tx_word(4'hF, 0);
    send_bit(1, 1); send_bit(0, 0);
    check("t5_busy_before_reset", busy, 1);
    #2 reset = 1'b0;
    #1;
    check("t5_async_dout", 32'(dout), 0);
    check("t5_async_flags", {dout_valid, busy, overrun, frame_err}, 0);
    tick(1);
    reset = 1'b1;
    tick(1);
    dout_ready = 1'b1;
    exp_q.push_back(4'h9);
    tx_word(4'h9, 0);
    check("t5_dout", 32'(dout), 32'h9);
    check("t5_frame_err", frame_err, 0);
    tick(1);

    // 6a: LSB-first instance
    l_ready = 1'b1;
    lexp_q.push_back(4'h1);
    lsb_bit(1, 1); lsb_bit(0, 0); lsb_bit(0, 0); lsb_bit(0, 0);
    check("t6_lsb_dout", 32'(l_dout), 32'h1);
    lexp_q.push_back(4'hB);
    lsb_bit(1, 1); lsb_bit(1, 0); lsb_bit(0, 0); lsb_bit(1, 0);
    tick(1);

    // 6b: loopback of every 4-bit pattern, back-to-back frames
    for (int p = 0; p < 16; p++) begin
      exp_q.push_back(4'(p));
      tx_word(4'(p), 0);
    end
    tick(3);
    check("t6_no_overrun", overrun, 0);

    check("msb_queue_empty", exp_q.size(), 0);
    check("lsb_queue_empty", lexp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_sipo_rx
`default_nettype wire
